// File: rtl/spi_mstr16_if.sv
// Host-side command/response bundle of the 16-bit SPI master.
// The inertial interface drives wrt/cmd; the master returns done/rd_data.
interface spi_mstr16_if;
  localparam int unsigned DW = 16;

  logic          wrt;
  logic [DW-1:0] cmd;
  logic          done;
  logic [DW-1:0] rd_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface

// File: rtl/spi_mstr16.sv
// 16-bit mode-3 SPI master: one shift register serves MOSI out and MISO in;
// SCLK is bit 4 of a free-running 5-bit divider, giving a 32-clk period.
module spi_mstr16 (
  input  logic               clk,
  input  logic               rst_n,
  spi_mstr16_if.slave        host,
  input  logic               MISO,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned VW = 5;

  // Divider preload puts the first SCLK fall 9 cycles after SS_n drops.
  localparam logic [VW-1:0] DIV_LOAD = 5'b10111;
  localparam logic [VW-1:0] DIV_RISE = 5'b01111;
  localparam logic [VW-1:0] DIV_FALL = 5'b11111;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   shft_q, shft_d;
  logic [VW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            miso_smpl_q, miso_smpl_d;
  logic            smpl_vld_q, smpl_vld_d;
  logic            ss_n_q, ss_n_d;
  logic            sclk_q, sclk_d;
  logic            done_q, done_d;

  // Next-state and datapath; all outputs are taken from flops below.
  always_comb begin
    state_d     = state_q;
    shft_d      = shft_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    miso_smpl_d = miso_smpl_q;
    smpl_vld_d  = smpl_vld_q;
    ss_n_d      = ss_n_q;
    sclk_d      = sclk_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        if (host.wrt) begin
          shft_d     = host.cmd;
          div_d      = DIV_LOAD;
          cnt_d      = '0;
          smpl_vld_d = 1'b0;
          done_d     = 1'b0;
          ss_n_d     = 1'b0;
          sclk_d     = DIV_LOAD[VW-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        div_d  = div_q + VW'(1);
        sclk_d = div_d[VW-1];
        if (div_q == DIV_RISE) begin
          miso_smpl_d = MISO;
          smpl_vld_d  = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = BACK;
          end
        end
        // The leading fall has nothing sampled yet, so it does not shift.
        if ((div_q == DIV_FALL) && smpl_vld_q) begin
          shft_d = {shft_q[DW-2:0], miso_smpl_q};
          cnt_d  = cnt_q + CW'(1);
        end
      end

      BACK: begin
        div_d  = div_q + VW'(1);
        sclk_d = 1'b1;
        if (div_q == DIV_FALL) begin
          shft_d  = {shft_q[DW-2:0], miso_smpl_q};
          cnt_d   = cnt_q + CW'(1);
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shft_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      miso_smpl_q <= 1'b0;
      smpl_vld_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shft_q      <= shft_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      miso_smpl_q <= miso_smpl_d;
      smpl_vld_q  <= smpl_vld_d;
      ss_n_q      <= ss_n_d;
      sclk_q      <= sclk_d;
      done_q      <= done_d;
    end
  end

  assign SS_n         = ss_n_q;
  assign SCLK         = sclk_q;
  assign MOSI         = shft_q[DW-1];
  assign host.done    = done_q;
  assign host.rd_data = shft_q;

endmodule

// File: tb/tb_spi_mstr16.sv
// Scoreboard bench for spi_mstr16: stimulus queues expected transactions,
// a negedge monitor measures the SPI pins and checks each completed one.
`timescale 1ns/1ps
module tb_spi_mstr16;

  localparam int LAT_EXP    = 522;
  localparam int SS_LOW_EXP = 521;
  localparam int FALLS_EXP  = 16;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] tx;
    int          wrt_cyc;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MISO, SS_n, SCLK, MOSI;
  bit          loop_md = 1'b1;
  logic [15:0] slv_word = 16'h0000;
  logic        slv_miso = 1'b0;
  int          sidx = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t sb[$];

  spi_mstr16_if host_if ();

  spi_mstr16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if),
    .MISO  (MISO),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign MISO = loop_md ? MOSI : slv_miso;

  // Mode-3 slave: presents the next bit on each SCLK fall, MSB first.
  always @(negedge SCLK or posedge SS_n) begin
    if (SS_n) begin
      sidx     = 0;
      slv_miso = 1'b0;
    end else begin
      slv_miso = slv_word[4'(15 - sidx)];
      sidx     = sidx + 1;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor state
  logic        ss_prev = 1'b1, sclk_prev = 1'b1, mosi_prev = 1'b0, done_prev = 1'b0;
  int          falls = 0, ss_low = 0, stab_err = 0, mosi_chg = 0;
  int          t_rise = 0, last_gap = 0;
  logic [15:0] rx = 16'h0000;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      ss_prev   = 1'b1;
      sclk_prev = 1'b1;
      mosi_prev = 1'b0;
      done_prev = 1'b0;
      falls     = 0;
      ss_low    = 0;
      stab_err  = 0;
      rx        = 16'h0000;
    end else begin
      if (ss_prev && !SS_n) begin
        last_gap = cyc - t_rise;
        falls    = 0;
        ss_low   = 0;
        stab_err = 0;
        mosi_chg = cyc;
        rx       = 16'h0000;
      end
      if (!ss_prev && SS_n) t_rise = cyc;
      if (!SS_n) ss_low++;
      if (MOSI !== mosi_prev) mosi_chg = cyc;
      if (sclk_prev && !SCLK) falls++;
      if (!sclk_prev && SCLK && !SS_n) begin
        rx = {rx[14:0], MOSI};
        if (cyc - mosi_chg < 16) stab_err++;
      end
      if (host_if.done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          chk("rd_data",     32'(host_if.rd_data), 32'(me.rd));
          chk("mosi_bits",   32'(rx),              32'(me.tx));
          chk("sclk_falls",  32'(falls),           32'(FALLS_EXP));
          chk("ss_low_len",  32'(ss_low),          32'(SS_LOW_EXP));
          chk("wrt_to_done", 32'(cyc - me.wrt_cyc), 32'(LAT_EXP));
          chk("mosi_stable", 32'(stab_err),        32'd0);
          if (me.gap != 0) chk("ss_high_gap", 32'(last_gap), 32'(me.gap));
        end
      end
      ss_prev   = SS_n;
      sclk_prev = SCLK;
      mosi_prev = MOSI;
      done_prev = host_if.done;
    end
  end

  // Drive wrt for one cycle from the current point; optionally queue the expectation.
  task automatic issue(input logic [15:0] c, input bit lb, input logic [15:0] rd,
                       input bit push, input int gap);
    exp_t e;
    loop_md      = lb;
    host_if.cmd  = c;
    host_if.wrt  = 1'b1;
    if (push) begin
      e.rd      = rd;
      e.tx      = c;
      e.wrt_cyc = cyc;
      e.gap     = gap;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 host_if.wrt = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (host_if.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bad;
    rst_n       = 1'b0;
    host_if.wrt = 1'b0;
    host_if.cmd = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_n",    32'(SS_n),            32'd1);
    chk("rst_sclk",    32'(SCLK),            32'd1);
    chk("rst_mosi",    32'(MOSI),            32'd0);
    chk("rst_done",    32'(host_if.done),    32'd0);
    chk("rst_rd_data", 32'(host_if.rd_data), 32'h0000);
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (SCLK !== 1'b1 || SS_n !== 1'b1 || host_if.done !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Loopback
    @(posedge clk); #1;
    issue(16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 0);
    wait_done(600);
    repeat (5) @(posedge clk);

    // WHO_AM_I read against the slave model
    slv_word = 16'h006A;
    @(posedge clk); #1;
    issue(16'h8F00, 1'b0, 16'h006A, 1'b1, 0);
    wait_done(600);
    repeat (5) @(posedge clk);

    // wrt during SHIFT (cycle 100) and BACK (cycle 515) must be ignored
    @(posedge clk); #1;
    issue(16'h1234, 1'b1, 16'h1234, 1'b1, 0);
    repeat (100) @(posedge clk);
    #1;
    host_if.cmd = 16'hFFFF;
    host_if.wrt = 1'b1;
    @(posedge clk);
    #1 host_if.wrt = 1'b0;
    repeat (414) @(posedge clk);
    #1;
    host_if.wrt = 1'b1;
    @(posedge clk);
    #1 host_if.wrt = 1'b0;
    wait_done(600);
    repeat (50) @(posedge clk);
    #1;
    chk("done_sticky", 32'(host_if.done),    32'd1);
    chk("rd_hold",     32'(host_if.rd_data), 32'h1234);

    // Back-to-back: second wrt in the first done cycle
    @(posedge clk); #1;
    issue(16'hF0F0, 1'b1, 16'hF0F0, 1'b1, 0);
    wait_done(600);
    issue(16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 1);
    chk("b2b_done_drop", 32'(host_if.done), 32'd0);
    chk("b2b_ss_low",    32'(SS_n),         32'd0);
    wait_done(600);
    repeat (5) @(posedge clk);

    // Reset at cycle 200 of a transfer
    @(posedge clk); #1;
    issue(16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 0);
    repeat (200) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ss_n",    32'(SS_n),            32'd1);
    chk("abort_sclk",    32'(SCLK),            32'd1);
    chk("abort_done",    32'(host_if.done),    32'd0);
    chk("abort_rd_data", 32'(host_if.rd_data), 32'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(host_if.done), 32'd0);
    issue(16'h3C5A, 1'b1, 16'h3C5A, 1'b1, 0);
    wait_done(600);

    repeat (20) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
